// File: rtl/rc_pkg.sv
// rc_pkg: shared types and constants for the remote command link.
package rc_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} rc_state_t;
  localparam int FRAME_BITS = 10;
  localparam int BAUD_DIV_DEFAULT = 2604;
endpackage

// File: rtl/rc_uart.sv
// rc_uart: 8N1 transmitter and receiver with a framing check on the stop bit.
module rc_uart import rc_pkg::*; #(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       TX,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_rdy
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] LAST = BW'(FRAME_BITS - 1);
  logic tx_busy, tx_tick;
  logic [CW-1:0] tx_cnt;
  logic [BW-1:0] tx_bit;
  logic [FRAME_BITS-1:0] tx_shift;
  logic r1, r2, r3, rx_busy, rx_tick;
  logic [CW-1:0] rx_cnt;
  logic [BW-1:0] rx_bit;
  logic [7:0] rx_shift;
  assign tx_tick = tx_busy && tx_cnt == FULL;
  // the start bit is re-checked after half a bit, every later bit after a full bit
  assign rx_tick = rx_busy && rx_cnt == (rx_bit == '0 ? HALF : FULL);
  assign rx_rdy = rx_tick && rx_bit == LAST && r2;
  assign rx_data = rx_shift;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_busy <= 1'b0;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_shift <= '1;
      tx_done <= 1'b0;
      TX <= 1'b1;
    end else begin
      TX <= tx_busy ? tx_shift[0] : 1'b1;
      tx_done <= tx_tick && tx_bit == LAST;
      if (!tx_busy && trmt) begin
        tx_busy <= 1'b1;
        tx_shift <= {1'b1, tx_data, 1'b0};
      end else if (tx_tick) begin
        tx_cnt <= '0;
        tx_shift <= {1'b1, tx_shift[FRAME_BITS-1:1]};
        tx_bit <= tx_bit == LAST ? '0 : tx_bit + 1'b1;
        tx_busy <= tx_bit != LAST;
      end else if (tx_busy)
        tx_cnt <= tx_cnt + 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r1 <= 1'b1;
      r2 <= 1'b1;
      r3 <= 1'b1;
      rx_busy <= 1'b0;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_shift <= '0;
    end else begin
      r1 <= RX;
      r2 <= r1;
      r3 <= r2;
      if (!rx_busy)
        rx_busy <= r3 && !r2;
      else if (rx_tick) begin
        rx_cnt <= '0;
        if ((rx_bit == '0 && r2) || rx_bit == LAST) begin
          rx_busy <= 1'b0;
          rx_bit <= '0;
        end else
          rx_bit <= rx_bit + 1'b1;
        if (rx_bit != '0 && rx_bit != LAST)
          rx_shift <= {r2, rx_shift[7:1]};
      end else
        rx_cnt <= rx_cnt + 1'b1;
    end
endmodule

// File: rtl/remote_comm.sv
// remote_comm: sends a 16-bit command as two UART bytes (high first) and captures the response byte.
module remote_comm import rc_pkg::*; #(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  input  logic        clr_resp_rdy,
  input  logic        RX,
  output logic        TX,
  output logic        cmd_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy
);
  rc_state_t state, nxt;
  logic [15:0] hold;
  logic go, trmt, tx_done, rx_rdy, accept;
  logic [7:0] tx_data, rx_data;
  assign accept = state == IDLE && snd_cmd;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (accept) nxt = HIGH;
    else if (state == HIGH && tx_done) nxt = LOW;
    else if (state == LOW && tx_done) nxt = IDLE;
  end
  always_comb begin
    trmt = go;
    tx_data = state == LOW ? hold[7:0] : hold[15:8];
  end
  // go is a one-cycle pulse on entry to HIGH or LOW, so each byte is requested once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold <= '0;
      go <= 1'b0;
      cmd_snt <= 1'b0;
      resp <= '0;
      resp_rdy <= 1'b0;
    end else begin
      go <= accept || (state == HIGH && tx_done);
      if (accept) hold <= cmd;
      cmd_snt <= accept ? 1'b0 : (state == LOW && tx_done) ? 1'b1 : cmd_snt;
      if (rx_rdy) resp <= rx_data;
      resp_rdy <= rx_rdy || (resp_rdy && !(clr_resp_rdy || accept));
    end
  rc_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk(clk),
    .rst(rst),
    .trmt(trmt),
    .tx_data(tx_data),
    .tx_done(tx_done),
    .TX(TX),
    .RX(RX),
    .rx_data(rx_data),
    .rx_rdy(rx_rdy)
  );
endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: directed stimulus with queue-based scoreboards for TX bytes and response bytes.
module tb_remote_comm;
  localparam int B = 16;
  logic clk = 0, rst = 1, snd_cmd = 0, clr_resp_rdy = 0, RX = 1;
  logic [15:0] cmd = '0;
  logic TX, cmd_snt, resp_rdy;
  logic [7:0] resp;
  int checks = 0, errors = 0, snt_rises = 0, cyc = 0;
  logic [7:0] exp_tx[$], exp_rx[$];
  int starts[$];
  always #5 clk = ~clk;
  remote_comm #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .snd_cmd(snd_cmd), .clr_resp_rdy(clr_resp_rdy),
    .RX(RX), .TX(TX), .cmd_snt(cmd_snt), .resp(resp), .resp_rdy(resp_rdy)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    cyc++;
  end
  // TX monitor: samples each bit near its start and near its end, so a wrong bit width drifts out
  initial begin
    logic [9:0] fa, fb;
    logic ab;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && TX === 1'b0) begin
        starts.push_back(cyc);
        ab = 0;
        for (int k = 0; k < 10 && !ab; k++)
          for (int c = 0; c < B && !ab; c++) begin
            if (k > 0 || c > 0) @(negedge clk);
            if (rst) ab = 1;
            if (c == 1) fa[k] = TX;
            if (c == B - 2) fb[k] = TX;
          end
        if (!ab) begin
          if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got frame %0h expected none", fa);
          end else begin
            e = exp_tx.pop_front();
            check("tx_frame_early", fa, {1'b1, e, 1'b0});
            check("tx_frame_late", fb, {1'b1, e, 1'b0});
          end
        end
      end
    end
  end
  initial begin
    logic p;
    p = 0;
    forever begin
      @(negedge clk);
      if (resp_rdy && !p) begin
        if (exp_rx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got %0h expected none", resp);
        end else
          check("resp_byte", resp, exp_rx.pop_front());
      end
      p = resp_rdy;
    end
  end
  initial begin
    logic p;
    p = 0;
    forever begin
      @(negedge clk);
      if (cmd_snt && !p) snt_rises++;
      p = cmd_snt;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic send(input logic [15:0] c);
    @(negedge clk);
    cmd = c;
    snd_cmd = 1;
    @(negedge clk);
    snd_cmd = 0;
  endtask
  task automatic wait_snt(input string name, input int lim);
    int n;
    n = 0;
    while (!cmd_snt && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(name, cmd_snt, 1);
  endtask
  task automatic send_rx(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      RX = f[k];
      repeat (B - 1) @(negedge clk);
    end
    @(negedge clk);
    RX = 1;
    repeat (4) @(negedge clk);
  endtask
  initial begin
    int r0, gap;
    repeat (3) @(negedge clk);
    check("rst_tx", TX, 1);
    check("rst_cmd_snt", cmd_snt, 0);
    check("rst_resp", resp, 8'h00);
    check("rst_resp_rdy", resp_rdy, 0);
    rst = 0;
    repeat (3) @(negedge clk);
    // 1: basic send
    starts.delete();
    exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'h3C);
    send(16'hA53C);
    wait_snt("s1_cmd_snt", 325);
    gap = starts.size() >= 2 ? starts[1] - starts[0] : 0;
    check("s1_byte_gap_ok", gap >= 10 * B && gap <= 10 * B + 2, 1);
    repeat (20) @(negedge clk);
    check("s1_cmd_snt_held", cmd_snt, 1);
    check("s1_tx_drained", exp_tx.size(), 0);
    // 2: busy ignore
    r0 = snt_rises;
    exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'h3C);
    send(16'hA53C);
    check("s2_cmd_snt_cleared", cmd_snt, 0);
    repeat (40) @(negedge clk);
    send(16'hFFFF);
    wait_snt("s2_cmd_snt", 330);
    repeat (200) @(negedge clk);
    check("s2_one_rise", snt_rises - r0, 1);
    check("s2_tx_drained", exp_tx.size(), 0);
    // 3: response capture, clear, set-wins
    exp_rx.push_back(8'h5A);
    send_rx(8'h5A, 1);
    check("s3_resp", resp, 8'h5A);
    check("s3_rdy", resp_rdy, 1);
    @(negedge clk);
    clr_resp_rdy = 1;
    @(negedge clk);
    clr_resp_rdy = 0;
    check("s3_rdy_cleared", resp_rdy, 0);
    check("s3_resp_kept", resp, 8'h5A);
    exp_rx.push_back(8'h66);
    fork
      send_rx(8'h66, 1);
      begin
        repeat (100) @(negedge clk);
        clr_resp_rdy = 1;
        repeat (70) @(negedge clk);
        clr_resp_rdy = 0;
      end
    join
    check("s3_set_wins", exp_rx.size(), 0);
    check("s3_resp_new", resp, 8'h66);
    check("s3_rdy_after_clr", resp_rdy, 0);
    // 4: framing error, then a good frame
    send_rx(8'h77, 0);
    check("s4_resp_unchanged", resp, 8'h66);
    check("s4_rdy_unchanged", resp_rdy, 0);
    exp_rx.push_back(8'h12);
    send_rx(8'h12, 1);
    check("s4_resp_good", resp, 8'h12);
    check("s4_rdy_good", resp_rdy, 1);
    // 5: full duplex
    exp_tx.push_back(8'h01);
    exp_tx.push_back(8'h02);
    exp_rx.push_back(8'hC3);
    fork
      begin
        send(16'h0102);
        wait_snt("s5_cmd_snt", 330);
      end
      begin
        repeat (175) @(negedge clk);
        send_rx(8'hC3, 1);
      end
    join
    check("s5_resp", resp, 8'hC3);
    check("s5_tx_drained", exp_tx.size(), 0);
    check("s5_rx_drained", exp_rx.size(), 0);
    // 6: reset mid-frame
    send(16'hABCD);
    repeat (2 + 3 * B + B / 2) @(negedge clk);
    #2 rst = 1;
    #1;
    check("s6_tx_async", TX, 1);
    check("s6_cmd_snt", cmd_snt, 0);
    check("s6_resp", resp, 8'h00);
    check("s6_rdy", resp_rdy, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    exp_tx.push_back(8'h12);
    exp_tx.push_back(8'h34);
    send(16'h1234);
    wait_snt("s6_cmd_snt_after", 325);
    repeat (5) @(negedge clk);
    check("s6_tx_drained", exp_tx.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/remote_comm.md
# remote_comm

Host-side command sender for the tour controller's serial link. It accepts a 16-bit command, serializes it over UART 8N1 as two bytes, high byte first. It signals completion with cmd_snt, and it captures the single-byte response returned by the controller. It sits in the remote/test-bench side of the design, facing the controller's command receiver across the TX/RX pair.

## Interface
- BAUD_DIV, 2604: clock cycles per bit; 2604 gives 19200 baud at 50 MHz. Must be at least 8.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd  in  16  command to send; sampled only on the cycle snd_cmd is accepted.
- snd_cmd  in  1  single-cycle request to send cmd.
- clr_resp_rdy  in  1  clears resp_rdy.
- RX  in  1  serial input from the controller; asynchronous to clk.
- TX  out  1  serial output to the controller; idles high.
- cmd_snt  out  1  set when both bytes have fully left TX; held until the next accepted snd_cmd.
- resp  out  8  last correctly framed response byte.
- resp_rdy  out  1  a new response byte is available.

## Operation
- Reset values: TX=1, cmd_snt=0, resp=8'h00, resp_rdy=0, FSM in IDLE, all counters 0.
- Command FSM states:
  - IDLE: on snd_cmd, latch cmd into a 16-bit hold register, clear cmd_snt, and go to HIGH.
  - HIGH: pulse trmt with tx_data=hold[15:8] for one cycle, wait for tx_done, then go to LOW.
  - LOW: pulse trmt with tx_data=hold[7:0], wait for tx_done, set cmd_snt, and go to IDLE.
- snd_cmd outside IDLE is ignored. The hold register and transmission are unaffected.
- TX frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly BAUD_DIV cycles.
- RX path:
  - RX is double-flop synchronized.
  - A falling edge in idle starts a frame; the start bit is re-checked at BAUD_DIV/2 and the frame is aborted if it reads 1.
  - Each following bit is sampled BAUD_DIV cycles later, at mid-bit.
  - If the stop bit is 1, resp is loaded and resp_rdy is set on the same edge.
  - If the stop bit is 0 (framing error), the byte is discarded and resp and resp_rdy are unchanged.
- resp_rdy is cleared by clr_resp_rdy or by an accepted snd_cmd. If a byte completes on the same cycle as a clear, set wins.
- RX and TX are independent and full-duplex. A response arriving mid-command is captured normally.
- A reset asserted mid-frame returns everything to reset values immediately. TX goes to 1 asynchronously, and no partial byte or cmd_snt is produced.

## Timing
- Accepted snd_cmd at edge N, then trmt for the high byte at edge N+1, then the TX start bit begins at edge N+2.
- The low byte's start bit begins no more than 2 cycles after the high byte's stop bit ends. No other idle gap is allowed.
- cmd_snt rises 1 cycle after the low byte's tx_done. Total latency is 20·BAUD_DIV + ≤5 cycles from snd_cmd.
- tx_done pulses for one cycle at the end of the stop bit.
- resp_rdy rises at the mid-stop-bit sample edge plus ≤3 cycles of synchronizer latency.
- The baud counter and bit counter widths are derived from BAUD_DIV and 10 bits per frame respectively. The bit counter never wraps past 9.

## Structure
- Package rc_pkg holds:
  - the rc_state_t enum {IDLE, HIGH, LOW};
  - localparam FRAME_BITS=10;
  - the default BAUD_DIV constant, shared with the controller-side receiver.
- One sub-module, rc_uart, contains the 8N1 transmitter (trmt, tx_data, tx_done, TX) and receiver (RX, rx_data, rx_rdy, framing check), parameterized by BAUD_DIV.
- remote_comm contains the command FSM, the hold register, the resp/resp_rdy set-reset flop, and cmd_snt.

## Test plan
All scenarios use BAUD_DIV=16.
1. Basic send: snd_cmd with cmd=16'hA53C. TX carries bytes 8'hA5 then 8'h3C, each bit exactly 16 cycles. cmd_snt rises within 325 cycles and holds until the next snd_cmd.
2. Busy ignore: a second snd_cmd with cmd=16'hFFFF during the HIGH byte leaves the wire bytes A5, 3C unchanged. Only one cmd_snt rise occurs.
3. Response capture: drive an RX frame carrying 8'h5A. resp=8'h5A and resp_rdy=1. Pulsing clr_resp_rdy clears resp_rdy while resp stays 8'h5A. A clr on the same cycle as a new byte's completion leaves resp_rdy=1.
4. Framing error: an RX frame carrying 8'h77 with stop bit 0 leaves resp and resp_rdy unchanged. A following good frame with 8'h12 is captured.
5. Full duplex: RX byte 8'hC3 arrives during the LOW byte of cmd 16'h0102. Both cmd_snt and resp=8'hC3 are correct.
6. Reset mid-frame: assert rst in the 4th bit of the high byte. TX=1 immediately and cmd_snt=0. After release, a new snd_cmd with 16'h1234 sends cleanly.
